// File: rtl/moving_average2_inverse.sv
`default_nettype none
// ============================================================================
// Module      : moving_average2_inverse
// Description : Rebuilds x[n] from a 2-tap moving-average stream.
//               The encoder computes y[n] = (x[n] + x[n-1]) >>> 1 and sends
//               the dropped sum LSB as the parity bit p[n].
//               This block computes x[n] = 2*y[n] + p[n] - x[n-1], saturates
//               the result, keeps a sticky range-error flag and counts the
//               decoded samples.
// Revision    : 1.0 - initial release
// ============================================================================
module moving_average2_inverse #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        system1000,
    input  logic                        system1000_rst,
    input  logic signed [WIDTH-1:0]     input_0,
    input  logic                        input_1,
    input  logic                        input_valid,
    input  logic                        seed_valid,
    input  logic signed [WIDTH-1:0]     seed_0,
    output logic signed [WIDTH-1:0]     output_0,
    output logic                        output_valid,
    output logic                        error_0,
    output logic        [CNT_WIDTH-1:0] count_0
);

    // Saturation limits, held at the width of the difference.
    localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] x_prev;

    // Decode datapath signals.
    logic signed [WIDTH-1:0] prev_eff;
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH+1:0] diff;
    logic signed [WIDTH-1:0] sat_val;
    logic                    sat_hit;

    // A seed arriving with a sample replaces x[n-1] for that same sample.
    // Concatenating y with p gives 2*y + p exactly, including y = -1, p = 1.
    always_comb begin
        prev_eff = seed_valid ? seed_0 : x_prev;
        sum      = {input_0, input_1};
        diff     = {sum[WIDTH], sum} - {{2{prev_eff[WIDTH-1]}}, prev_eff};
        sat_hit  = 1'b0;
        sat_val  = diff[WIDTH-1:0];
        if (diff > SAT_MAX) begin
            sat_hit = 1'b1;
            sat_val = SAT_MAX[WIDTH-1:0];
        end else if (diff < SAT_MIN) begin
            sat_hit = 1'b1;
            sat_val = SAT_MIN[WIDTH-1:0];
        end
    end

    // State, history, output registers and RUN/FAULT control.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state        <= ST_RUN;
            x_prev       <= '0;
            output_0     <= '0;
            output_valid <= 1'b0;
            error_0      <= 1'b0;
            count_0      <= '0;
        end else begin
            output_valid <= input_valid;

            // Seed resynchronises history and clears the fault condition.
            if (seed_valid) begin
                state   <= ST_RUN;
                x_prev  <= seed_0;
                count_0 <= '0;
                error_0 <= 1'b0;
            end

            // Decode takes precedence on the shared registers; the count
            // restarts from one when a seed arrived in the same cycle.
            if (input_valid) begin
                output_0 <= sat_val;
                x_prev   <= sat_val;
                count_0  <= seed_valid ? CNT_ONE : count_0 + CNT_ONE;
                if (sat_hit) begin
                    state   <= ST_FAULT;
                    error_0 <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_moving_average2_inverse.sv
`default_nettype none
// ============================================================================
// Module      : tb_moving_average2_inverse
// Description : Self-checking bench: vector table plus scoreboard queue,
//               with hand-written sequences for seed, gap and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moving_average2_inverse;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 16;

    logic                        clk;
    logic                        rst;
    logic signed [WIDTH-1:0]     y_in;
    logic                        p_in;
    logic                        in_valid;
    logic                        seed_valid;
    logic signed [WIDTH-1:0]     seed;
    logic signed [WIDTH-1:0]     out;
    logic                        out_valid;
    logic                        err;
    logic        [CNT_WIDTH-1:0] cnt;

    moving_average2_inverse #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .input_0        (y_in),
        .input_1        (p_in),
        .input_valid    (in_valid),
        .seed_valid     (seed_valid),
        .seed_0         (seed),
        .output_0       (out),
        .output_valid   (out_valid),
        .error_0        (err),
        .count_0        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int out;
        int err;
        int cnt;
    } exp_t;

    typedef struct {
        int y;
        int p;
        int out;
    } vec_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state.
    int m_prev = 0;
    int m_err  = 0;
    int m_cnt  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model step; returns the decoded sample and updates model state.
    task automatic model_step(input int y, input int p, input int sv, input int sd,
                              output int x);
        int prev;
        prev = sv ? sd : m_prev;
        if (sv) begin
            m_err = 0;
            m_cnt = 0;
        end
        x = 2 * y + p - prev;
        if (x > 127) begin x = 127; m_err = 1; end
        else if (x < -128) begin x = -128; m_err = 1; end
        m_prev = x;
        m_cnt  = (m_cnt + 1) % 65536;
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out", int'(out), e.out);
                check("err", int'(err), e.err);
                check("cnt", int'(cnt), e.cnt);
            end
        end
    end

    // Drive one sample (optionally with seed) for one cycle.
    task automatic send(input int y, input int p, input int sv, input int sd,
                        input int use_tab, input int tab_out);
        int   x;
        exp_t e;
        model_step(y, p, sv, sd, x);
        e.out = use_tab ? tab_out : x;
        e.err = m_err;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        y_in       = WIDTH'(y);
        p_in       = p[0];
        seed       = WIDTH'(sd);
        seed_valid = sv[0];
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        seed_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_prev = 0;
        m_err  = 0;
        m_cnt  = 0;
    endtask

    task automatic drain;
        idle(1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t vecs[5];

    initial begin
        int held;
        rst = 1'b0; y_in = '0; p_in = 1'b0; in_valid = 1'b0;
        seed_valid = 1'b0; seed = '0;

        vecs[0] = '{y: 5,  p: 0, out: 10};
        vecs[1] = '{y: 15, p: 0, out: 20};
        vecs[2] = '{y: 7,  p: 1, out: -5};
        vecs[3] = '{y: 63, p: 1, out: 127};
        vecs[4] = '{y: -1, p: 1, out: -128};

        // Reset state
        do_reset();
        check("rst_out", int'(out), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_cnt", int'(cnt), 0);

        // Basic stream, back to back
        for (int i = 0; i < 3; i++) send(vecs[i].y, vecs[i].p, 0, 0, 1, vecs[i].out);
        drain();
        check("basic_cnt", int'(cnt), 3);
        check("basic_err", int'(err), 0);

        // Extremes from reset history
        do_reset();
        for (int i = 3; i < 5; i++) send(vecs[i].y, vecs[i].p, 0, 0, 1, vecs[i].out);
        drain();
        check("ext_err", int'(err), 0);

        // Overflow, sticky fault, seed clears it
        do_reset();
        send(127, 1, 0, 0, 1, 127);
        send(0, 0, 0, 0, 1, -127);
        drain();
        check("ovf_err_sticky", int'(err), 1);
        seed = 8'sd0; seed_valid = 1'b1;
        @(posedge clk); #1; seed_valid = 1'b0;
        m_prev = 0; m_err = 0; m_cnt = 0;
        check("seed_err_clr", int'(err), 0);
        check("seed_cnt_clr", int'(cnt), 0);
        check("seed_no_valid", int'(out_valid), 0);
        send(3, 0, 0, 0, 1, 6);
        drain();

        // Negative overflow
        send(-128, 0, 0, 0, 1, -128);
        drain();
        check("neg_ovf_err", int'(err), 1);

        // Seed together with a sample
        send(30, 0, 1, 50, 1, 10);
        drain();
        check("seed_sample_cnt", int'(cnt), 1);
        check("seed_sample_err", int'(err), 0);

        // Gaps of three idle cycles
        send(20, 1, 0, 0, 0, 0);
        idle(1);
        held = int'(out);
        for (int i = 0; i < 3; i++) begin
            check("gap_valid", int'(out_valid), 0);
            check("gap_hold", int'(out), held);
            idle(1);
        end
        send(25, 0, 0, 0, 0, 0);
        send(-10, 1, 0, 0, 0, 0);
        drain();

        // Pseudo-random stream against the model
        for (int i = 0; i < 40; i++)
            send($signed($urandom_range(255)) - 128, int'($urandom_range(1)), 0, 0, 0, 0);
        drain();

        // Reset coincident with a sample discards it
        y_in = 8'sd9; p_in = 1'b0; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        m_prev = 0; m_err = 0; m_cnt = 0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_out", int'(out), 0);
        check("midrst_cnt", int'(cnt), 0);
        send(5, 0, 0, 0, 1, 10);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
